// File: rtl/usr_pkg.sv
// Shared types for the usr_burst shift register / burst serializer.
// Op encodings, FSM states and the beat-counter width helper.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } usr_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_t;

    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-q and outgoing-lane logic for one lane-wide op.
// Burst beats reuse this block through its SHL/SHR paths.
import usr_pkg::*;

module usr_shift_core #(
    parameter int WIDTH = 8,
    parameter int SW    = 1
) (
    input  logic [WIDTH-1:0] q,
    input  usr_op_t          op,
    input  logic [SW-1:0]    serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q_next,
    output logic [SW-1:0]    serial_out,
    output logic             serial_valid
);

    always_comb begin
        q_next       = q;
        serial_out   = '0;
        serial_valid = 1'b0;
        unique case (op)
            OP_HOLD: q_next = q;
            OP_LOAD: q_next = parallel_in;
            OP_SHL: begin
                q_next       = {q[WIDTH-SW-1:0], serial_in};
                serial_out   = q[WIDTH-1 -: SW];
                serial_valid = 1'b1;
            end
            OP_SHR: begin
                q_next       = {serial_in, q[WIDTH-1:SW]};
                serial_out   = q[SW-1:0];
                serial_valid = 1'b1;
            end
            OP_ROL: begin
                q_next       = {q[WIDTH-SW-1:0], q[WIDTH-1 -: SW]};
                serial_out   = q[WIDTH-1 -: SW];
                serial_valid = 1'b1;
            end
            OP_ROR: begin
                q_next       = {q[SW-1:0], q[WIDTH-1:SW]};
                serial_out   = q[SW-1:0];
                serial_valid = 1'b1;
            end
            OP_ASR: begin
                q_next       = {{SW{q[WIDTH-1]}}, q[WIDTH-1:SW]};
                serial_out   = q[SW-1:0];
                serial_valid = 1'b1;
            end
            OP_CLR: q_next = '0;
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// Universal shift register with an autonomous burst serializer.
// One start shifts a parallel word out over BEATS cycles and captures serial_in.
import usr_pkg::*;

module usr_burst #(
    parameter int WIDTH = 8,
    parameter int SW    = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             dir,
    input  logic [SW-1:0]    serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [SW-1:0]    serial_out,
    output logic             serial_valid,
    output logic [WIDTH-1:0] parallel_out,
    output logic             busy,
    output logic             done
);

    localparam int BEATS = WIDTH / SW;
    localparam int CW    = cnt_width(BEATS);

    usr_state_t       state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             dir_q, dir_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] q, q_n;

    usr_op_t          core_op;
    logic [WIDTH-1:0] core_q;

    // During a burst the core is steered to plain SHL/SHR by the latched dir.
    always_comb begin
        core_op = usr_op_t'(op);
        if (state_q == SHIFT)
            core_op = dir_q ? OP_SHR : OP_SHL;
    end

    usr_shift_core #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_core (
        .q            (q),
        .op           (core_op),
        .serial_in    (serial_in),
        .parallel_in  (parallel_in),
        .q_next       (core_q),
        .serial_out   (serial_out),
        .serial_valid (serial_valid)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        done_n  = 1'b0;
        q_n     = q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    q_n     = parallel_in;
                    dir_n   = dir;
                    cnt_n   = CW'(BEATS);
                    state_n = SHIFT;
                end else begin
                    q_n = core_q;
                end
            end
            SHIFT: begin
                q_n   = core_q;
                cnt_n = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            q       <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
            done_q  <= done_n;
            q       <= q_n;
        end
    end

    assign parallel_out = q;
    assign busy         = (state_q == SHIFT);
    assign done         = done_q;

endmodule

// File: tb/tb_usr_burst.sv
// Self-checking bench for usr_burst: direct ops (SW=1) and bursts (SW=2).
// Expected burst lanes come from a small model and are queued at start.
module tb_usr_burst;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] a_op;
    logic       a_start, a_dir;
    logic [0:0] a_si;
    logic [7:0] a_pin;
    logic [0:0] a_so;
    logic       a_sv, a_busy, a_done;
    logic [7:0] a_q;

    logic [2:0] b_op;
    logic       b_start, b_dir;
    logic [1:0] b_si;
    logic [7:0] b_pin;
    logic [1:0] b_so;
    logic       b_sv, b_busy, b_done;
    logic [7:0] b_q;

    logic [1:0] sb[$];

    usr_burst #(.WIDTH(8), .SW(1)) dut_a (
        .clk(clk), .res(res), .op(a_op), .start(a_start), .dir(a_dir),
        .serial_in(a_si), .parallel_in(a_pin), .serial_out(a_so),
        .serial_valid(a_sv), .parallel_out(a_q), .busy(a_busy), .done(a_done)
    );

    usr_burst #(.WIDTH(8), .SW(2)) dut_b (
        .clk(clk), .res(res), .op(b_op), .start(b_start), .dir(b_dir),
        .serial_in(b_si), .parallel_in(b_pin), .serial_out(b_so),
        .serial_valid(b_sv), .parallel_out(b_q), .busy(b_busy), .done(b_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference burst: queue departing lanes, return the final register.
    task automatic model_push(input logic [7:0] w, input logic d,
                              input logic [7:0] ln, output logic [7:0] qf);
        logic [1:0] si;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(d ? w[1:0] : w[7:6]);
            si = ln[7-2*i -: 2];
            w  = d ? {si, w[7:2]} : {w[5:0], si};
        end
        qf = w;
    endtask

    task automatic start_b(input logic [7:0] w, input logic d,
                           input logic [7:0] ln, output logic [7:0] qe);
        b_pin   = w;
        b_dir   = d;
        b_start = 1'b1;
        model_push(w, d, ln, qe);
        tick();
        b_start = 1'b0;
        b_dir   = ~d;
        b_pin   = 8'h00;
    endtask

    task automatic beats_b(input logic [7:0] ln, input int poke);
        logic [1:0] e;
        for (int i = 0; i < 4; i++) begin
            b_si = ln[7-2*i -: 2];
            if (i == poke) begin
                b_op = 3'b111; b_start = 1'b1; b_pin = 8'hFF;
            end
            #1;
            checks++;
            if (b_busy !== 1'b1) begin
                failures++;
                $display("FAIL beat%0d_busy got=%b exp=1", i, b_busy);
            end
            checks++;
            if (b_done !== 1'b0) begin
                failures++;
                $display("FAIL beat%0d_done got=%b exp=0", i, b_done);
            end
            checks++;
            if (b_sv !== 1'b1) begin
                failures++;
                $display("FAIL beat%0d_valid got=%b exp=1", i, b_sv);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL beat%0d_lane unexpected lane got=%b", i, b_so);
            end else begin
                e = sb.pop_front();
                if (b_so !== e) begin
                    failures++;
                    $display("FAIL beat%0d_lane got=%b exp=%b", i, b_so, e);
                end
            end
            tick();
            b_op = 3'b000; b_start = 1'b0;
        end
    endtask

    task automatic done_b(input logic [7:0] qe);
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL done_cycle got done=%b busy=%b exp done=1 busy=0",
                     b_done, b_busy);
        end
        checks++;
        if (b_q !== qe) begin
            failures++;
            $display("FAIL burst_q got=%h exp=%h", b_q, qe);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL lanes_left got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset;
        res = 1'b1;
        a_op = 3'b000; a_start = 1'b0; a_dir = 1'b0; a_si = '0; a_pin = '0;
        b_op = 3'b000; b_start = 1'b0; b_dir = 1'b0; b_si = '0; b_pin = '0;
        #12;
        checks++;
        if (a_q !== 8'h00 || a_busy !== 1'b0 || a_done !== 1'b0 ||
            a_sv !== 1'b0 || a_so !== 1'b0) begin
            failures++;
            $display("FAIL reset_a got q=%h busy=%b done=%b sv=%b so=%b exp all 0",
                     a_q, a_busy, a_done, a_sv, a_so);
        end
        checks++;
        if (b_q !== 8'h00 || b_busy !== 1'b0 || b_done !== 1'b0 ||
            b_sv !== 1'b0 || b_so !== 2'b00) begin
            failures++;
            $display("FAIL reset_b got q=%h busy=%b done=%b sv=%b so=%b exp all 0",
                     b_q, b_busy, b_done, b_sv, b_so);
        end
        @(negedge clk);
        res = 1'b0;
        tick();
    endtask

    task automatic test_direct;
        a_op = 3'b001; a_pin = 8'hA5; tick();
        a_op = 3'b010; a_si = 1'b1; #1;
        checks++;
        if (a_so !== 1'b1 || a_sv !== 1'b1) begin
            failures++;
            $display("FAIL shl_lane got so=%b sv=%b exp so=1 sv=1", a_so, a_sv);
        end
        tick();
        checks++;
        if (a_q !== 8'h4B) begin
            failures++;
            $display("FAIL shl_q got=%h exp=4b", a_q);
        end
        a_op = 3'b001; a_pin = 8'h81; tick();
        a_op = 3'b101; tick();
        checks++;
        if (a_q !== 8'hC0) begin
            failures++;
            $display("FAIL ror_q got=%h exp=c0", a_q);
        end
        a_op = 3'b001; a_pin = 8'h80; tick();
        a_op = 3'b110; tick();
        checks++;
        if (a_q !== 8'hC0) begin
            failures++;
            $display("FAIL asr_q got=%h exp=c0", a_q);
        end
        a_op = 3'b100; a_si = 1'b0; tick();
        checks++;
        if (a_q !== 8'h81) begin
            failures++;
            $display("FAIL rol_q got=%h exp=81", a_q);
        end
        a_op = 3'b011; a_si = 1'b1; tick();
        checks++;
        if (a_q !== 8'hC0) begin
            failures++;
            $display("FAIL shr_q got=%h exp=c0", a_q);
        end
        a_op = 3'b111; tick();
        checks++;
        if (a_q !== 8'h00) begin
            failures++;
            $display("FAIL clr_q got=%h exp=00", a_q);
        end
        a_op = 3'b001; a_pin = 8'h3C; tick();
        a_op = 3'b000; a_pin = 8'hFF; #1;
        checks++;
        if (a_so !== 1'b0 || a_sv !== 1'b0) begin
            failures++;
            $display("FAIL hold_lane got so=%b sv=%b exp so=0 sv=0", a_so, a_sv);
        end
        tick();
        checks++;
        if (a_q !== 8'h3C) begin
            failures++;
            $display("FAIL hold_q got=%h exp=3c", a_q);
        end
    endtask

    task automatic test_burst(input logic d);
        logic [7:0] qe;
        start_b(8'hB4, d, 8'h6C, qe);
        beats_b(8'h6C, -1);
        done_b(qe);
        tick();
        checks++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done got done=%b busy=%b exp 0 0", b_done, b_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] qe, qe2;
        start_b(8'hB4, 1'b0, 8'h6C, qe);
        beats_b(8'h6C, 1);
        done_b(qe);
        start_b(8'h5A, 1'b1, 8'hD2, qe2);
        beats_b(8'hD2, -1);
        done_b(qe2);
        tick();
    endtask

    task automatic test_reset_mid;
        logic [7:0] qe;
        start_b(8'hB4, 1'b0, 8'h6C, qe);
        b_si = 2'b01;
        tick();
        #2;
        res = 1'b1;
        #1;
        checks++;
        if (b_q !== 8'h00 || b_busy !== 1'b0 || b_sv !== 1'b0 || b_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got q=%h busy=%b sv=%b done=%b exp all 0",
                     b_q, b_busy, b_sv, b_done);
        end
        sb.delete();
        #2;
        res = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (b_done !== 1'b0 || b_busy !== 1'b0) begin
                failures++;
                $display("FAIL post_reset%0d got done=%b busy=%b exp 0 0",
                         i, b_done, b_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_burst(1'b0);
        test_burst(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
